// File: rtl/scan_pkg.sv
// Shared constants and types for the decoder scan-address sequencer.
package scan_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef struct packed {
    logic       mode;
    logic       dir;
    logic [3:0] lo;
    logic [3:0] hi;
  } scan_cfg_t;

  // True when addr sits on the final address of the sweep for the latched direction.
  function automatic logic at_range_end(scan_cfg_t cfg, logic [3:0] addr);
    return (cfg.dir == DIR_UP) ? (addr == cfg.hi) : (addr == cfg.lo);
  endfunction

endpackage

// File: rtl/scan_addr_seq_if.sv
// Control and status bundle between a scan-sequencer client and scan_addr_seq.
// Handshake: start/stop are single-cycle request pulses sampled on every rising
// edge with no ready/back-pressure; busy/tick/done/A* are registered status.
interface scan_addr_seq_if #(parameter int DWELL_W = 16);
  logic               start;
  logic               stop;
  logic               mode;
  logic               dir;
  logic [3:0]         lo;
  logic [3:0]         hi;
  logic [DWELL_W-1:0] dwell;
  logic               A3;
  logic               A2;
  logic               A1;
  logic               A0;
  logic               busy;
  logic               tick;
  logic               done;
  logic [0:0]         state;

  modport master (
    output start, stop, mode, dir, lo, hi, dwell,
    input  A3, A2, A1, A0, busy, tick, done, state
  );

  modport slave (
    input  start, stop, mode, dir, lo, hi, dwell,
    output A3, A2, A1, A0, busy, tick, done, state
  );
endinterface

// File: rtl/scan_addr_seq_dwell_timer.sv
// Prescale counter: expire is high on the last cycle of each dwell period.
module dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] limit,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  assign expire = (count == limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= expire ? '0 : count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/scan_addr_seq.sv
// Steps a 4-bit decoder select address through [lo..hi] with a programmable dwell,
// continuous or single-sweep, up or down.
module scan_addr_seq
  import scan_pkg::*;
#(
  parameter int DWELL_W = 16
) (
  input logic             clk,
  input logic             rst,
  scan_addr_seq_if.slave  bus
);

  logic [0:0]         state;
  logic [3:0]         addr;
  scan_cfg_t          cfg;
  logic [DWELL_W-1:0] dwell_l;
  logic               busy;
  logic               tick;
  logic               done;

  logic start_ok;
  logic stop_run;
  logic expire;
  logic running;

  assign running  = (state == ST_RUN);
  assign start_ok = bus.start && (bus.lo <= bus.hi);
  // stop only matters in RUN; there it outranks a restart or an advance
  assign stop_run = bus.stop && running;

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_ok || stop_run),
    .en     (running),
    .limit  (dwell_l),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= 4'h0;
      cfg     <= '0;
      dwell_l <= '0;
      busy    <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (stop_run) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (start_ok) begin
        cfg     <= '{mode: bus.mode, dir: bus.dir, lo: bus.lo, hi: bus.hi};
        dwell_l <= bus.dwell;
        addr    <= (bus.dir == DIR_DOWN) ? bus.hi : bus.lo;
        busy    <= 1'b1;
        state   <= ST_RUN;
      end else if (running && expire) begin
        if (at_range_end(cfg, addr)) begin
          if (cfg.mode == MODE_SINGLE) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tick <= 1'b1;
            addr <= (cfg.dir == DIR_UP) ? cfg.lo : cfg.hi;
          end
        end else begin
          tick <= 1'b1;
          addr <= (cfg.dir == DIR_UP) ? addr + 4'd1 : addr - 4'd1;
        end
      end
    end
  end

  assign {bus.A3, bus.A2, bus.A1, bus.A0} = addr;
  assign bus.busy  = busy;
  assign bus.tick  = tick;
  assign bus.done  = done;
  assign bus.state = state;

endmodule
